whack_detector: RTL and testbench

WHACK_DETECTOR -- requirements
Module: whack_detector

---
 rtl/whack_pkg.sv | 23 ++
 rtl/button_debouncer.sv | 63 ++++++
 rtl/whack_detector.sv | 108 ++++++++++
 tb/tb_whack_detector.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/whack_pkg.sv
// ---------------------------------------------------------------------------
// whack_pkg
// Shared definitions for the whack-a-mole hit detector: the detector FSM
// state type and the default timing / counter-width parameters.
//   DEBOUNCE_CYCLES_DEF : stable clocks before a button vector is accepted
//                         (1 ms at 14 MHz)
//   SCORE_W_DEF         : width of the score and miss counters
//   N_HOLES             : number of mole holes / pushbuttons
// ---------------------------------------------------------------------------
package whack_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 14000;
    localparam int SCORE_W_DEF         = 8;
    localparam int N_HOLES             = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HIT     = 2'd2,
        LOCKOUT = 2'd3
    } whack_state_t;

endpackage

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
// Synchronizes a raw pushbutton vector into the clock domain, debounces it
// with one shared stability counter and emits a one-clock registered pulse
// for every button that rises in the accepted vector.
// Ports:
//   clock_14MHz_i : clock, rising edge
//   reset_i       : asynchronous active-high reset
//   buttons_i     : raw asynchronous buttons, active-high
//   press_evt_o   : registered rising edges of the accepted vector (1 clock)
// ---------------------------------------------------------------------------
module button_debouncer
    import whack_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int WIDTH           = N_HOLES
) (
    input  logic             clock_14MHz_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] buttons_i,
    output logic [WIDTH-1:0] press_evt_o
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [WIDTH-1:0] cand;      // vector currently being timed for stability
    logic [WIDTH-1:0] accepted;  // last vector that survived a full debounce
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock_14MHz_i or posedge reset_i) begin
        if (reset_i) begin
            sync_p0     <= '0;
            sync_p1     <= '0;
            cand        <= '0;
            cnt         <= '0;
            accepted    <= '0;
            press_evt_o <= '0;
        end else begin
            // synchronizer stage boundary
            sync_p0     <= buttons_i;
            sync_p1     <= sync_p0;
            press_evt_o <= '0;

            // Any change anywhere in the vector restarts the shared count;
            // the count parks at CNT_MAX once the vector has been stable.
            if (sync_p1 != cand) begin
                cand <= sync_p1;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                // accepted catches up with cand here, so the edge term is
                // nonzero for exactly one clock per accepted change
                accepted    <= cand;
                press_evt_o <= cand & ~accepted;
            end
        end
    end

endmodule

// File: rtl/whack_detector.sv
// ---------------------------------------------------------------------------
// whack_detector
// Judges debounced button presses against the currently raised mole and
// keeps saturating hit / miss counts.
// Ports:
//   clock_14MHz_i : clock, rising edge
//   reset_i       : asynchronous active-high reset
//   mole_i        : one-hot mole position, all-zero when no mole is up
//   round_tick_i  : one-clock pulse marking a mole refresh
//   buttons_i     : raw asynchronous pushbuttons, bit i aligned to mole bit i
//   whacked_o     : high from a hit until the next round tick
//   hit_pulse_o   : one-clock pulse per hit
//   miss_pulse_o  : one-clock pulse per miss
//   score_o       : saturating hit count
//   misses_o      : saturating miss count
// Build option:
//   WHACK_TIMEOUT_MISS_EN : when defined, a round tick while still armed
//                           with no press counts as a miss
// ---------------------------------------------------------------------------
module whack_detector
    import whack_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SCORE_W         = SCORE_W_DEF
) (
    input  logic               clock_14MHz_i,
    input  logic               reset_i,
    input  logic [N_HOLES-1:0] mole_i,
    input  logic               round_tick_i,
    input  logic [N_HOLES-1:0] buttons_i,
    output logic               whacked_o,
    output logic               hit_pulse_o,
    output logic               miss_pulse_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [SCORE_W-1:0] misses_o
);

    logic [N_HOLES-1:0] press_evt;
    whack_state_t       state;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .WIDTH           (N_HOLES)
    ) u_debouncer (
        .clock_14MHz_i (clock_14MHz_i),
        .reset_i       (reset_i),
        .buttons_i     (buttons_i),
        .press_evt_o   (press_evt)
    );

    always_ff @(posedge clock_14MHz_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= IDLE;
            whacked_o    <= 1'b0;
            hit_pulse_o  <= 1'b0;
            miss_pulse_o <= 1'b0;
            score_o      <= '0;
            misses_o     <= '0;
        end else begin
            hit_pulse_o  <= 1'b0;
            miss_pulse_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (mole_i != '0)
                        state <= ARMED;
                end
                ARMED: begin
                    // Exact match only: several buttons including the right
                    // one is still a miss.
                    if (press_evt != '0) begin
                        if (press_evt == mole_i) begin
                            hit_pulse_o <= 1'b1;
                            score_o     <= sat_inc(score_o);
                            whacked_o   <= 1'b1;
                            state       <= HIT;
                        end else begin
                            miss_pulse_o <= 1'b1;
                            misses_o     <= sat_inc(misses_o);
                            state        <= LOCKOUT;
                        end
                    end
`ifdef WHACK_TIMEOUT_MISS_EN
                    else if (round_tick_i) begin
                        miss_pulse_o <= 1'b1;
                        misses_o     <= sat_inc(misses_o);
                    end
`endif
                end
                HIT, LOCKOUT: begin
                end
                default: state <= IDLE;
            endcase

            // A round tick overrides whatever the state logic chose, so a
            // press scored in the same cycle never leaves whacked_o high.
            if (round_tick_i) begin
                state     <= (mole_i != '0) ? ARMED : IDLE;
                whacked_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_whack_detector.sv
module tb_whack_detector;

    localparam int DB     = 16;
    localparam int SW     = 8;
    localparam int SMAX   = (1 << SW) - 1;
    localparam int HOLD   = DB + 12;
    localparam int SETTLE = DB + 12;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [15:0]   mole_i;
    logic          round_tick_i;
    logic [15:0]   buttons_i;
    logic          whacked_o;
    logic          hit_pulse_o;
    logic          miss_pulse_o;
    logic [SW-1:0] score_o;
    logic [SW-1:0] misses_o;

    always #5 clk = ~clk;

    whack_detector #(
        .DEBOUNCE_CYCLES (DB),
        .SCORE_W         (SW)
    ) dut (
        .clock_14MHz_i (clk),
        .reset_i       (reset_i),
        .mole_i        (mole_i),
        .round_tick_i  (round_tick_i),
        .buttons_i     (buttons_i),
        .whacked_o     (whacked_o),
        .hit_pulse_o   (hit_pulse_o),
        .miss_pulse_o  (miss_pulse_o),
        .score_o       (score_o),
        .misses_o      (misses_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // pulse counters fed from the DUT, compared against model totals
    int hits_seen = 0;
    int miss_seen = 0;
    always @(negedge clk) begin
        if (hit_pulse_o)  hits_seen++;
        if (miss_pulse_o) miss_seen++;
    end

    // game-level reference model
    int          exp_hits    = 0;
    int          exp_mpulses = 0;
    int          exp_score   = 0;
    int          exp_misses  = 0;
    int          exp_whacked = 0;
    int          rnd_state   = 0;   // 0: no mole, 1: waiting for a press, 2: round decided
    logic [15:0] cur_mole    = '0;
    int          lat         = DB + 5;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= SMAX) ? SMAX : v + 1;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".hit_pulses"},  hits_seen, exp_hits);
        chk({tag, ".miss_pulses"}, miss_seen, exp_mpulses);
        chk({tag, ".score"},       int'(score_o), exp_score);
        chk({tag, ".misses"},      int'(misses_o), exp_misses);
        chk({tag, ".whacked"},     int'(whacked_o), exp_whacked);
    endtask

    task automatic model_press(input logic [15:0] vec);
        if (rnd_state == 1 && vec != '0) begin
            if (vec == cur_mole) begin
                exp_hits++;
                exp_score   = sat(exp_score);
                exp_whacked = 1;
            end else begin
                exp_mpulses++;
                exp_misses = sat(exp_misses);
            end
            rnd_state = 2;
        end
    endtask

    task automatic do_tick(input logic [15:0] m);
        @(negedge clk);
        mole_i       = m;
        round_tick_i = 1'b1;
        @(negedge clk);
        round_tick_i = 1'b0;
`ifdef WHACK_TIMEOUT_MISS_EN
        if (rnd_state == 1) begin
            exp_mpulses++;
            exp_misses = sat(exp_misses);
        end
`endif
        exp_whacked = 0;
        cur_mole    = m;
        rnd_state   = (m != '0) ? 1 : 0;
        repeat (2) @(negedge clk);
        check_all("tick");
    endtask

    task automatic do_press(input logic [15:0] vec);
        @(negedge clk);
        buttons_i = vec;
        repeat (HOLD) @(negedge clk);
        buttons_i = '0;
        repeat (SETTLE) @(negedge clk);
        model_press(vec);
        check_all("press");
    endtask

    task automatic do_glitch(input logic [15:0] vec);
        for (int g = 0; g < 6; g++) begin
            @(negedge clk);
            buttons_i = vec;
            repeat (5) @(negedge clk);
            buttons_i = '0;
            repeat (5) @(negedge clk);
        end
        repeat (SETTLE) @(negedge clk);
        check_all("glitch");
    endtask

    function automatic logic [15:0] other_bit(input logic [15:0] m);
        logic [15:0] v;
        v = 16'(1) << $urandom_range(0, 15);
        if (v == m) v = {v[14:0], v[15]};
        return v;
    endfunction

    initial begin
        logic [15:0] v;
        logic [15:0] m;
        int          found;
        int          r;

        reset_i      = 1'b1;
        mole_i       = '0;
        round_tick_i = 1'b0;
        buttons_i    = '0;
        repeat (3) @(negedge clk);
        check_all("reset");
        reset_i = 1'b0;
        repeat (2) @(negedge clk);

        // single correct press held for a long time: one hit only
        do_tick(16'h0010);
        @(negedge clk);
        buttons_i = 16'h0010;
        found = 0;
        for (int i = 1; i <= DB + 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (hit_pulse_o && found == 0) begin
                lat   = i;
                found = 1;
            end
        end
        if (found == 0 || lat < DB + 2 || lat > DB + 8) begin
            n_cmp++;
            n_bad++;
            $display("FAIL press_latency: got %0d expected %0d..%0d", lat, DB + 2, DB + 8);
            lat = DB + 5;
        end
        repeat (20000 - DB - 40) @(negedge clk);
        buttons_i = '0;
        repeat (SETTLE) @(negedge clk);
        model_press(16'h0010);
        check_all("long_hold");
        chk("long_hold.score_is_1", int'(score_o), 1);
        repeat (50) @(negedge clk);
        chk("whacked_persists", int'(whacked_o), 1);
        do_tick(16'h0010);

        // wrong button, then the right one in the same round
        do_press(16'h0020);
        chk("wrong.misses_is_1", int'(misses_o), 1);
        do_press(16'h0010);

        // short glitches never get accepted
        do_tick(16'h0010);
        do_glitch(16'h0010);
        do_press(16'h0010);

        // round passes with no press
        do_tick(16'h0400);
        do_tick(16'h0400);
`ifdef WHACK_TIMEOUT_MISS_EN
        chk("timeout.misses", int'(misses_o), 2);
`else
        chk("timeout.misses", int'(misses_o), 1);
`endif

        // correct press landing in the same cycle as a round tick
        do_tick(16'h0010);
        @(negedge clk);
        buttons_i = 16'h0010;
        repeat (lat - 1) @(posedge clk);
        @(negedge clk);
        round_tick_i = 1'b1;
        @(negedge clk);
        round_tick_i = 1'b0;
        model_press(16'h0010);
        exp_whacked = 0;
        rnd_state   = 1;
        chk("coinc.whacked", int'(whacked_o), 0);
        repeat (HOLD) @(negedge clk);
        buttons_i = '0;
        repeat (SETTLE) @(negedge clk);
        check_all("coinc");
        do_press(16'h0010);

        // randomized play
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                if ($urandom_range(0, 3) == 0) m = '0;
                else                           m = 16'(1) << $urandom_range(0, 15);
                do_tick(m);
            end else if (r <= 4) begin
                v = (cur_mole != '0) ? cur_mole : (16'(1) << $urandom_range(0, 15));
                do_press(v);
            end else if (r <= 6) begin
                do_press(other_bit(cur_mole));
            end else if (r == 7) begin
                v = other_bit(cur_mole);
                v = (cur_mole != '0) ? (cur_mole | v) : (v | {v[14:0], v[15]});
                do_press(v);
            end else if (r == 8) begin
                do_glitch(16'(1) << $urandom_range(0, 15));
            end else begin
                do_press(16'(1) << $urandom_range(0, 15));
            end
        end

        // drive the score to saturation, then one more hit
        while (exp_score < SMAX) begin
            m = 16'(1) << $urandom_range(0, 15);
            do_tick(m);
            do_press(m);
        end
        do_tick(16'h8000);
        do_press(16'h8000);
        chk("sat.score", int'(score_o), SMAX);
        chk("sat.hit_pulses", hits_seen, exp_hits);

        // reset in the middle of a debounce
        do_tick(16'h0010);
        do_press(16'h0001);
        do_tick(16'h0010);
        @(negedge clk);
        buttons_i = 16'h0010;
        repeat (8) @(posedge clk);
        #2 reset_i = 1'b1;
        #1;
        chk("rst_async.score",   int'(score_o), 0);
        chk("rst_async.misses",  int'(misses_o), 0);
        chk("rst_async.whacked", int'(whacked_o), 0);
        chk("rst_async.hit",     int'(hit_pulse_o), 0);
        chk("rst_async.miss",    int'(miss_pulse_o), 0);
        buttons_i = '0;
        repeat (3) @(negedge clk);
        reset_i     = 1'b0;
        exp_score   = 0;
        exp_misses  = 0;
        exp_whacked = 0;
        rnd_state   = 1;
        repeat (3 * DB) @(negedge clk);
        check_all("post_reset");
        do_press(16'h0010);
        chk("post_reset.score_is_1", int'(score_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
